// File: rtl/pma_arbiter.sv
// Physical memory attribute checker shared between fetch and data ports.
// Alternating arbitration, 1-entry result registers, saturating violation count.
package pma_pkg;
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
    logic        executable;
    logic        read_only;
    logic        idempotent;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_DEFAULT = '{
    base:       32'h0000_0000,
    mask:       32'h0000_0000,
    executable: 1'b1,
    read_only:  1'b0,
    idempotent: 1'b1
  };
endpackage

module pma_arbiter
  import pma_pkg::*;
#(
  parameter int       PMA_REGIONS = 1,
  parameter pma_cfg_t PMA_CFG [PMA_REGIONS-1:0] =
    '{default: PMA_DEFAULT}
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_f_req_i,
  input  logic [31:0] s_f_addr_i,
  output logic        s_f_gnt_o,
  output logic        s_f_rvalid_o,
  input  logic        s_f_rready_i,
  output logic        s_f_violation_o,
  output logic        s_f_idempotent_o,
  input  logic        s_d_req_i,
  input  logic [31:0] s_d_addr_i,
  input  logic        s_d_write_i,
  output logic        s_d_gnt_o,
  output logic        s_d_rvalid_o,
  input  logic        s_d_rready_i,
  output logic        s_d_violation_o,
  output logic        s_d_idempotent_o,
  input  logic        s_viol_clr_i,
  output logic [7:0]  s_viol_cnt_o
);

  logic        f_elig;
  logic        d_elig;
  logic        last_d;
  logic        any_gnt;

  logic        chk_data;
  logic        chk_write;
  logic [31:0] chk_addr;
  logic        chk_viol;
  logic        chk_idem;

  logic [PMA_REGIONS-1:0] hit;
  logic [PMA_REGIONS-1:0] no_exec;
  logic [PMA_REGIONS-1:0] ro_hit;
  logic [PMA_REGIONS-1:0] idem_hit;

  logic        f_rvalid_q;
  logic        f_viol_q;
  logic        f_idem_q;
  logic        d_rvalid_q;
  logic        d_viol_q;
  logic        d_idem_q;
  logic [7:0]  cnt_q;

  assign f_elig = s_f_req_i &&
                  (!f_rvalid_q || s_f_rready_i);
  assign d_elig = s_d_req_i &&
                  (!d_rvalid_q || s_d_rready_i);

  // last_d=1 means data won last; fetch wins a tie then
  always_comb begin
    s_f_gnt_o = 1'b0;
    s_d_gnt_o = 1'b0;
    priority case (1'b1)
      !s_resetn_i: begin
        s_f_gnt_o = 1'b0;
        s_d_gnt_o = 1'b0;
      end
      f_elig && d_elig: begin
        s_f_gnt_o = last_d;
        s_d_gnt_o = !last_d;
      end
      f_elig: s_f_gnt_o = 1'b1;
      d_elig: s_d_gnt_o = 1'b1;
      default: begin
        s_f_gnt_o = 1'b0;
        s_d_gnt_o = 1'b0;
      end
    endcase
  end

  assign any_gnt   = s_f_gnt_o || s_d_gnt_o;
  assign chk_data  = s_d_gnt_o;
  assign chk_write = chk_data && s_d_write_i;
  assign chk_addr  = chk_data ? s_d_addr_i
                              : s_f_addr_i;

  for (genvar g = 0; g < PMA_REGIONS; g++)
  begin : g_region
    assign hit[g] =
      (chk_addr & PMA_CFG[g].mask) ==
      PMA_CFG[g].base;
    assign no_exec[g] =
      hit[g] && !PMA_CFG[g].executable;
    assign ro_hit[g] =
      hit[g] && PMA_CFG[g].read_only;
    assign idem_hit[g] =
      hit[g] && PMA_CFG[g].idempotent;
  end

  assign chk_viol = !(|hit) ||
                    (!chk_data && (|no_exec)) ||
                    (chk_write && (|ro_hit));
  assign chk_idem = |idem_hit;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      last_d <= 1'b1;
    end else if (any_gnt) begin
      last_d <= s_d_gnt_o;
    end
  end

  // a same-cycle regrant refills the slot instead of draining it
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      f_rvalid_q <= 1'b0;
      f_viol_q   <= 1'b0;
      f_idem_q   <= 1'b0;
    end else if (s_f_gnt_o) begin
      f_rvalid_q <= 1'b1;
      f_viol_q   <= chk_viol;
      f_idem_q   <= chk_idem;
    end else if (s_f_rready_i) begin
      f_rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      d_rvalid_q <= 1'b0;
      d_viol_q   <= 1'b0;
      d_idem_q   <= 1'b0;
    end else if (s_d_gnt_o) begin
      d_rvalid_q <= 1'b1;
      d_viol_q   <= chk_viol;
      d_idem_q   <= chk_idem;
    end else if (s_d_rready_i) begin
      d_rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      cnt_q <= 8'd0;
    end else if (s_viol_clr_i) begin
      cnt_q <= 8'd0;
    end else if (any_gnt && chk_viol &&
                 cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign s_f_rvalid_o     = f_rvalid_q;
  assign s_f_violation_o  = f_viol_q;
  assign s_f_idempotent_o = f_idem_q;
  assign s_d_rvalid_o     = d_rvalid_q;
  assign s_d_violation_o  = d_viol_q;
  assign s_d_idempotent_o = d_idem_q;
  assign s_viol_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pma_arbiter.sv
// Scoreboard bench for pma_arbiter: drivers queue expected results on grant,
// a negedge monitor pops them on each consumed result.
module tb_pma_arbiter;
  import pma_pkg::*;

  localparam pma_cfg_t R0 = '{base: 32'h0000_0000,
    mask: 32'hFFFF_0000, executable: 1'b1,
    read_only: 1'b0, idempotent: 1'b1};
  localparam pma_cfg_t R1 = '{base: 32'h1000_0000,
    mask: 32'hFFFF_0000, executable: 1'b0,
    read_only: 1'b1, idempotent: 1'b1};
  localparam pma_cfg_t R2 = '{base: 32'h2000_0000,
    mask: 32'hF000_0000, executable: 1'b0,
    read_only: 1'b0, idempotent: 1'b0};
  localparam pma_cfg_t R3 = '{base: 32'h0000_8000,
    mask: 32'hFFFF_8000, executable: 1'b1,
    read_only: 1'b1, idempotent: 1'b0};
  localparam pma_cfg_t TB_CFG [3:0] =
    '{R3, R2, R1, R0};

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic        viol;
    logic        idem;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        f_req, f_gnt, f_rvalid, f_rready;
  logic [31:0] f_addr;
  logic        f_viol, f_idem;
  logic        d_req, d_gnt, d_rvalid, d_rready;
  logic [31:0] d_addr;
  logic        d_write, d_viol, d_idem;
  logic        clr;
  logic [7:0]  cnt;

  int          ntests = 0;
  int          nfail = 0;
  vec_t        fv[$];
  vec_t        dv[$];
  logic [1:0]  fq[$];
  logic [1:0]  dq[$];
  string       glog = "";

  pma_arbiter #(
    .PMA_REGIONS(4),
    .PMA_CFG(TB_CFG)
  ) dut (
    .s_clk_i(clk),
    .s_resetn_i(rst_n),
    .s_f_req_i(f_req),
    .s_f_addr_i(f_addr),
    .s_f_gnt_o(f_gnt),
    .s_f_rvalid_o(f_rvalid),
    .s_f_rready_i(f_rready),
    .s_f_violation_o(f_viol),
    .s_f_idempotent_o(f_idem),
    .s_d_req_i(d_req),
    .s_d_addr_i(d_addr),
    .s_d_write_i(d_write),
    .s_d_gnt_o(d_gnt),
    .s_d_rvalid_o(d_rvalid),
    .s_d_rready_i(d_rready),
    .s_d_violation_o(d_viol),
    .s_d_idempotent_o(d_idem),
    .s_viol_clr_i(clr),
    .s_viol_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm,
                         input string act,
                         input string exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got '%s' expected '%s'",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a,
                              input logic w,
                              input logic v,
                              input logic i);
    vec_t r;
    r.addr = a;
    r.wr   = w;
    r.viol = v;
    r.idem = i;
    return r;
  endfunction

  task automatic run_f();
    vec_t v;
    bit   got;
    int   w;
    while (fv.size() != 0) begin
      v = fv.pop_front();
      f_req = 1'b1;
      f_addr = v.addr;
      got = 1'b0;
      w = 0;
      while (!got && w < 64) begin
        @(negedge clk);
        got = f_gnt;
        @(posedge clk);
        #1;
        w++;
      end
      if (!got) begin
        ntests++;
        nfail++;
        $display("FAIL f_gnt_timeout: none for %h",
                 v.addr);
      end else begin
        fq.push_back({v.viol, v.idem});
      end
    end
    f_req = 1'b0;
  endtask

  task automatic run_d();
    vec_t v;
    bit   got;
    int   w;
    while (dv.size() != 0) begin
      v = dv.pop_front();
      d_req = 1'b1;
      d_addr = v.addr;
      d_write = v.wr;
      got = 1'b0;
      w = 0;
      while (!got && w < 64) begin
        @(negedge clk);
        got = d_gnt;
        @(posedge clk);
        #1;
        w++;
      end
      if (!got) begin
        ntests++;
        nfail++;
        $display("FAIL d_gnt_timeout: none for %h",
                 v.addr);
      end else begin
        dq.push_back({v.viol, v.idem});
      end
    end
    d_req = 1'b0;
    d_write = 1'b0;
  endtask

  logic rst_q = 1'b0;
  logic fg_q, frv_q, frr_q, fvi_q, fid_q;
  logic dg_q, drv_q, drr_q, dvi_q, did_q;
  logic [1:0] e;

  always @(negedge clk) begin
    if (rst_n && rst_q) begin
      chk("f_rvalid_timing", 32'(f_rvalid),
          32'(fg_q | (frv_q & ~frr_q)));
      chk("d_rvalid_timing", 32'(d_rvalid),
          32'(dg_q | (drv_q & ~drr_q)));
      if (frv_q && !frr_q)
        chk("f_hold", 32'({f_viol, f_idem}),
            32'({fvi_q, fid_q}));
      if (drv_q && !drr_q)
        chk("d_hold", 32'({d_viol, d_idem}),
            32'({dvi_q, did_q}));
    end
    if (rst_n) begin
      if (f_gnt) glog = {glog, "F"};
      if (d_gnt) glog = {glog, "D"};
      if (f_gnt || d_gnt) begin
        chk("one_gnt", 32'(f_gnt & d_gnt), 32'd0);
        chk("gnt_has_req",
            32'((f_gnt & ~f_req) | (d_gnt & ~d_req)),
            32'd0);
      end
      if (f_rvalid && f_rready) begin
        if (fq.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL f_result: unexpected rvalid");
        end else begin
          e = fq.pop_front();
          chk("f_result", 32'({f_viol, f_idem}),
              32'(e));
        end
      end
      if (d_rvalid && d_rready) begin
        if (dq.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL d_result: unexpected rvalid");
        end else begin
          e = dq.pop_front();
          chk("d_result", 32'({d_viol, d_idem}),
              32'(e));
        end
      end
    end
    rst_q = rst_n;
    fg_q = f_gnt; frv_q = f_rvalid;
    frr_q = f_rready;
    fvi_q = f_viol; fid_q = f_idem;
    dg_q = d_gnt; drv_q = d_rvalid;
    drr_q = d_rready;
    dvi_q = d_viol; did_q = d_idem;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    f_req = 1'b0; f_addr = '0; f_rready = 1'b0;
    d_req = 1'b0; d_addr = '0; d_rready = 1'b0;
    d_write = 1'b0; clr = 1'b0;
    #1 rst_n = 1'b0;
    f_req = 1'b1;
    d_req = 1'b1;
    @(negedge clk);
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
    chk("rst_results",
        32'({f_viol, f_idem, d_viol, d_idem}), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // alternation under continuous contention
    @(posedge clk);
    #1;
    f_rready = 1'b1;
    d_rready = 1'b1;
    glog = "";
    fv.push_back(mk(32'h0000_0100, 0, 0, 1));
    fv.push_back(mk(32'h1000_0000, 0, 1, 1));
    fv.push_back(mk(32'h3000_0000, 0, 1, 0));
    fv.push_back(mk(32'h0000_8000, 0, 0, 1));
    dv.push_back(mk(32'h1000_0010, 0, 0, 1));
    dv.push_back(mk(32'h1000_0010, 1, 1, 1));
    dv.push_back(mk(32'h2000_0004, 1, 0, 0));
    dv.push_back(mk(32'h4000_0000, 0, 1, 0));
    fork
      run_f();
      run_d();
    join
    @(negedge clk);
    chk_str("alt_order", glog, "FDFDFDFD");
    chk("cnt_after_alt", 32'(cnt), 32'd4);

    // fetch backpressure, data keeps flowing
    @(posedge clk);
    #1;
    f_rready = 1'b0;
    glog = "";
    fv.push_back(mk(32'h2000_0000, 0, 1, 0));
    fv.push_back(mk(32'h0000_0004, 0, 0, 1));
    dv.push_back(mk(32'h2000_0008, 0, 0, 0));
    dv.push_back(mk(32'h0000_8004, 1, 1, 1));
    dv.push_back(mk(32'h0000_8004, 0, 0, 1));
    fork
      run_f();
      run_d();
      begin
        repeat (5) @(posedge clk);
        #1 f_rready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_gnt", 32'(f_gnt), 32'd1);
      end
    join
    @(negedge clk);
    chk_str("bp_order", glog, "FDDDF");
    chk("cnt_after_bp", 32'(cnt), 32'd6);

    // saturation
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++)
      fv.push_back(mk(32'h3000_0000, 0, 1, 0));
    run_f();
    @(negedge clk);
    chk("cnt_saturated", 32'(cnt), 32'd255);

    // clear wins over a simultaneous violating grant
    @(posedge clk);
    #1;
    f_req = 1'b1;
    f_addr = 32'h3000_0000;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_gnt", 32'(f_gnt), 32'd1);
    if (f_gnt) fq.push_back(2'b10);
    @(posedge clk);
    #1;
    clr = 1'b0;
    f_req = 1'b0;
    @(negedge clk);
    chk("cnt_cleared", 32'(cnt), 32'd0);

    // reset while both results are pending
    @(posedge clk);
    #1;
    f_rready = 1'b0;
    d_rready = 1'b0;
    fv.push_back(mk(32'h1000_0000, 0, 1, 1));
    dv.push_back(mk(32'h1000_0000, 0, 0, 1));
    fork
      run_f();
      run_d();
    join
    @(negedge clk);
    chk("pend_rvalid", 32'({f_rvalid, d_rvalid}),
        32'b11);
    chk("pend_cnt", 32'(cnt), 32'd1);
    #2 rst_n = 1'b0;
    fq.delete();
    dq.delete();
    #1;
    chk("rst_mid_rvalid", 32'({f_rvalid, d_rvalid}),
        32'd0);
    chk("rst_mid_results",
        32'({f_viol, f_idem, d_viol, d_idem}), 32'd0);
    chk("rst_mid_cnt", 32'(cnt), 32'd0);
    f_req = 1'b1;
    d_req = 1'b1;
    @(negedge clk);
    chk("rst_mid_gnt", 32'({f_gnt, d_gnt}), 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    f_rready = 1'b1;
    d_rready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'({f_rvalid, d_rvalid}),
        32'd0);
    @(posedge clk);
    #1;
    glog = "";
    fv.push_back(mk(32'h0000_8000, 0, 0, 1));
    dv.push_back(mk(32'h2000_0000, 1, 0, 0));
    fork
      run_f();
      run_d();
    join
    repeat (2) @(negedge clk);
    chk_str("post_rst_order", glog, "FD");
    chk("sb_f_empty", 32'(fq.size()), 32'd0);
    chk("sb_d_empty", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pma_arbiter.md
PMA_ARBITER -- requirements
Module: pma_arbiter

Interface
REQ-001 SHALL take parameter PMA_REGIONS, default 1: number of attribute regions.
REQ-002 SHALL take parameter PMA_CFG (pma_cfg_t array [PMA_REGIONS-1:0]), default '{default:PMA_DEFAULT}: per-region base, mask, executable, read_only and idempotent.
REQ-003 SHALL have port s_clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port s_resetn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_f_req_i, input, 1 bit: fetch lookup request.
REQ-006 SHALL have port s_f_addr_i, input, 32 bits: fetch address.
REQ-007 SHALL have port s_f_gnt_o, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port s_f_rvalid_o, output, 1 bit: fetch result held valid.
REQ-009 SHALL have port s_f_rready_i, input, 1 bit: fetch result consumed.
REQ-010 SHALL have ports s_f_violation_o and s_f_idempotent_o, outputs, 1 bit each: fetch result.
REQ-011 SHALL have ports s_d_req_i (input, 1 bit), s_d_addr_i (input, 32 bits) and s_d_write_i (input, 1 bit): data lookup request, address and write flag.
REQ-012 SHALL have ports s_d_gnt_o, s_d_rvalid_o, s_d_violation_o and s_d_idempotent_o (outputs, 1 bit each) and s_d_rready_i (input, 1 bit): data channel, same meaning as the fetch channel.
REQ-013 SHALL have port s_viol_clr_i, input, 1 bit: synchronous clear of the violation counter.
REQ-014 SHALL have port s_viol_cnt_o, output, 8 bits: saturating count of granted lookups that produced a violation.

Function
REQ-015 SHALL contain one shared attribute checker; at most one lookup is granted per cycle.
REQ-016 Region hit SHALL be (addr & mask) == base, evaluated for every region in parallel.
REQ-017 Violation SHALL be: no region hit, OR any hit region with !executable (fetch lookup), OR any hit region with read_only while s_d_write_i=1 (data lookup).
REQ-018 Idempotent SHALL be the OR of idempotent over all hit regions; it is reported independently of violation.
REQ-019 Each channel SHALL have a 1-entry result register; a channel is eligible when req=1 and (rvalid=0 or rready=1).
REQ-020 Grants SHALL be combinational from req, rvalid, rready and arbiter state; gnt is never asserted without req.
REQ-021 Arbitration:
  - only one channel eligible -> grant that channel;
  - both eligible -> grant the channel not granted most recently (1-bit last_grant register, updated on every grant).
REQ-022 Result latency SHALL be 1 cycle: a grant in cycle N sets rvalid and loads violation/idempotent in cycle N+1.
REQ-023 rvalid SHALL clear on rready=1 unless a new grant to the same channel occurs in that cycle, in which case the new result replaces the old one with rvalid held at 1 (back-to-back throughput of 1 per cycle).
REQ-024 While rvalid=1 and rready=0, result outputs SHALL hold stable; rready with rvalid=0 SHALL have no effect.
REQ-025 Requesters SHALL hold req, addr and write stable until gnt; the block does not latch ungranted requests.
REQ-026 The counter SHALL increment by 1 on each granted lookup whose computed violation is 1 and saturate at 255.
REQ-027 s_viol_clr_i SHALL force the counter to 0 in the next cycle and take priority over a simultaneous increment.

Reset
REQ-028 While s_resetn_i=0, the following SHALL hold asynchronously: rvalid outputs 0, violation outputs 0, idempotent outputs 0, s_viol_cnt_o 0, last_grant = data, so fetch wins the first contention.
REQ-029 Reset asserted mid-operation SHALL discard pending results without producing an rvalid pulse; gnt outputs remain combinational and SHALL be 0 while in reset.

Verification
REQ-030 Both channels request continuously with rready=1 -> grants alternate F,D,F,D starting with F after reset; each rvalid follows its gnt by 1 cycle.
REQ-031 Fetch to a region with executable=0 -> s_f_violation_o=1 and s_viol_cnt_o increments by 1; an address hitting no region -> violation=1.
REQ-032 Data write to a read_only region -> violation=1; a read to the same address -> violation=0, with idempotent equal to the region attribute.
REQ-033 Fetch rvalid=1 with rready=0 and both channels requesting -> fetch not granted and data granted every cycle; asserting rready -> fetch granted in that same cycle.
REQ-034 300 violating lookups -> count holds at 255; s_viol_clr_i asserted together with a violating grant -> count 0 next cycle.
REQ-035 Reset asserted with both rvalid=1 -> both rvalid drop immediately; after release the first contention is granted to fetch.
